// File: rtl/lpaccel_pkg.sv
// lpaccel_pkg: shared tile index, accumulator state and saturating-add helper
package lpaccel_pkg;

    typedef struct packed {
        logic [2:0] i;
        logic [2:0] j;
    } tile_idx_t;

    typedef enum logic {ACC, DRAIN} tacc_state_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int width);
        logic [32:0] s;
        logic [32:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (33'd1 << width) - 33'd1;
        return s > m ? m[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/tile_accum.sv
// tile_accum: accumulates NPASS streamed passes into a ROWS x COLS saturating tile, then drains it
module tile_accum
    import lpaccel_pkg::*;
#(
    parameter int DW    = 4,
    parameter int AW    = 11,
    parameter int ROWS  = 2,
    parameter int COLS  = 4,
    parameter int NPASS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output tile_idx_t     out_idx,
    output logic          out_last
);

    localparam int RI = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CI = COLS > 1 ? $clog2(COLS) : 1;
    localparam int PW = NPASS > 1 ? $clog2(NPASS) : 1;

    tacc_state_t   state, state_d;
    logic [2:0]    i, j;
    logic [PW-1:0] pass;
    logic [AW-1:0] acc [ROWS][COLS];
    logic          last_j, last_e, last_p, beat, xfer;

    always_comb begin
        last_j  = j == 3'(COLS - 1);
        last_e  = last_j && i == 3'(ROWS - 1);
        last_p  = pass == PW'(NPASS - 1);
        beat    = state == ACC && in_valid;
        xfer    = state == DRAIN && out_ready;
        state_d = beat && last_e && last_p ? DRAIN : xfer && last_e ? ACC : state;
    end

    assign in_ready  = state == ACC;
    assign out_valid = state == DRAIN;
    assign out_last  = out_valid && last_e;
    assign out_idx   = {i, j};
    assign out_data  = acc[i[RI-1:0]][j[CI-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACC;
        else state <= state_d;
    end

    // Accepting a beat and draining an element walk the tile in the same raster order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i    <= '0;
            j    <= '0;
            pass <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    acc[r][c] <= '0;
        end else begin
            if (beat || xfer) begin
                j <= last_j ? 3'd0 : j + 3'd1;
                if (last_j) i <= last_e ? 3'd0 : i + 3'd1;
            end
            if (beat) begin
                acc[i[RI-1:0]][j[CI-1:0]] <= AW'(sat_add(32'(acc[i[RI-1:0]][j[CI-1:0]]), 32'(in_data), AW));
                if (last_e) pass <= last_p ? '0 : pass + 1'b1;
            end
            if (xfer && last_e)
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        acc[r][c] <= '0;
        end
    end

endmodule
